// File: rtl/logic_gates_pkg.sv
// Shared definitions for the logic-gate checker: FSM states, the fixed
// stimulus vector table and small arithmetic helpers.
package logic_gates_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
  localparam logic [1:0]  LAST_INDEX          = 2'd3;

  // Entry i occupies bits [2i+1:2i] as {A,B}: 0={0,0}, 1={1,0}, 2={0,1}, 3={1,1}
  localparam logic [7:0] VEC_TABLE = {2'b11, 2'b01, 2'b10, 2'b00};

  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    return VEC_TABLE[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] val);
    return (val == 3'd7) ? 3'd7 : (val + 3'd1);
  endfunction

endpackage

// File: rtl/logic_gates_checker_gates_expect.sv
// Reference gate model: the values a correct AND/OR/NOT DUT must return.
module gates_expect (
  input  logic A,
  input  logic B,
  output logic expAnd,
  output logic expOr,
  output logic expNot
);

  assign expAnd = A & B;
  assign expOr  = A | B;
  assign expNot = ~A;

endmodule

// File: rtl/logic_gates_checker.sv
// Walks the four-vector truth table through an external gate DUT, waits
// HOLD_CYCLES per vector, and records error count and first failure.
module logic_gates_checker
  import logic_gates_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  output logic       oA,
  output logic       oB,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [2:0] oErrCnt,
  output logic [1:0] oFailVec,
  output logic [2:0] oFailBits
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_index;
  logic [3:0] r_settle_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err_cnt;
  logic [1:0] r_fail_vec;
  logic [2:0] r_fail_bits;

  state_t     w_state_nxt;
  logic [1:0] w_index_nxt;
  logic [3:0] w_settle_nxt;
  logic       w_a_nxt;
  logic       w_b_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pass_nxt;
  logic [2:0] w_err_nxt;
  logic [1:0] w_fail_vec_nxt;
  logic [2:0] w_fail_bits_nxt;

  logic       w_exp_and;
  logic       w_exp_or;
  logic       w_exp_not;
  logic [2:0] w_mismatch;
  logic [2:0] w_err_upd;

  gates_expect u_expect (
    .A      (r_a),
    .B      (r_b),
    .expAnd (w_exp_and),
    .expOr  (w_exp_or),
    .expNot (w_exp_not)
  );

  assign w_mismatch = {iAnd ^ w_exp_and, iOr ^ w_exp_or, iNot ^ w_exp_not};
  assign w_err_upd  = (|w_mismatch) ? sat_inc3(r_err_cnt) : r_err_cnt;

  // Next-state and next-register values for the sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_settle_nxt    = r_settle_cnt;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_pass_nxt      = r_pass;
    w_err_nxt       = r_err_cnt;
    w_fail_vec_nxt  = r_fail_vec;
    w_fail_bits_nxt = r_fail_bits;

    case (r_state)
      ST_IDLE: begin
        w_a_nxt = 1'b0;
        w_b_nxt = 1'b0;
        if (iStart) begin
          w_done_nxt      = 1'b0;
          w_pass_nxt      = 1'b0;
          w_err_nxt       = 3'd0;
          w_fail_vec_nxt  = 2'd0;
          w_fail_bits_nxt = 3'd0;
          w_index_nxt     = 2'd0;
          w_settle_nxt    = 4'd0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = ST_DRIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        {w_a_nxt, w_b_nxt} = vec_ab(r_index);
        w_settle_nxt       = 4'd0;
        w_state_nxt        = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (r_settle_cnt == HOLD_LAST) begin
          w_settle_nxt = 4'd0;
          w_state_nxt  = ST_CHECK;
        end else begin
          w_settle_nxt = r_settle_cnt + 4'd1;
        end
      end

      ST_CHECK: begin
        w_err_nxt = w_err_upd;
        // A zero count before this check means no earlier vector failed
        if ((|w_mismatch) && (r_err_cnt == 3'd0)) begin
          w_fail_vec_nxt  = r_index;
          w_fail_bits_nxt = w_mismatch;
        end else begin
          w_fail_vec_nxt  = r_fail_vec;
          w_fail_bits_nxt = r_fail_bits;
        end
        if (r_index == LAST_INDEX) begin
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_upd == 3'd0);
          w_busy_nxt  = 1'b0;
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
          w_state_nxt = ST_DONE;
        end else begin
          w_index_nxt = r_index + 2'd1;
          w_state_nxt = ST_DRIVE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state      <= ST_IDLE;
      r_index      <= 2'd0;
      r_settle_cnt <= 4'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= 3'd0;
      r_fail_vec   <= 2'd0;
      r_fail_bits  <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err_cnt    <= w_err_nxt;
      r_fail_vec   <= w_fail_vec_nxt;
      r_fail_bits  <= w_fail_bits_nxt;
    end
  end

  assign oA        = r_a;
  assign oB        = r_b;
  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oPass     = r_pass;
  assign oErrCnt   = r_err_cnt;
  assign oFailVec  = r_fail_vec;
  assign oFailBits = r_fail_bits;

endmodule

// File: tb/tb_logic_gates_checker.sv
// Self-checking bench: a behavioural gate DUT with injectable faults and a
// scoreboard of expected run results compared when oDone rises.
module tb_logic_gates_checker;

  localparam int HOLD   = 4;
  localparam int PERIOD = HOLD + 2;
  localparam int RUN_EDGES = 4 * PERIOD;

  localparam int F_NONE      = 0;
  localparam int F_AND_SA0   = 1;
  localparam int F_NOT_BUF   = 2;

  typedef struct {
    logic [2:0] err;
    logic [1:0] fvec;
    logic [2:0] fbits;
    logic       pass;
  } exp_t;

  logic       iClk;
  logic       iRst_n;
  logic       iStart;
  logic       oA;
  logic       oB;
  logic       iAnd;
  logic       iOr;
  logic       iNot;
  logic       oBusy;
  logic       oDone;
  logic       oPass;
  logic [2:0] oErrCnt;
  logic [1:0] oFailVec;
  logic [2:0] oFailBits;

  int   fault_mode;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  logic [1:0] tb_vec [4];

  logic_gates_checker #(.HOLD_CYCLES(HOLD)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .oA        (oA),
    .oB        (oB),
    .iAnd      (iAnd),
    .iOr       (iOr),
    .iNot      (iNot),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oPass     (oPass),
    .oErrCnt   (oErrCnt),
    .oFailVec  (oFailVec),
    .oFailBits (oFailBits)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Gate DUT under test, with optional planted faults
  always_comb begin
    iAnd = (fault_mode == F_AND_SA0) ? 1'b0 : (oA & oB);
    iOr  = oA | oB;
    iNot = (fault_mode == F_NOT_BUF) ? oA : ~oA;
  end

  function automatic exp_t model_run(input int fm);
    exp_t e;
    logic a, b, ga, go, gn;
    logic [2:0] m;
    e.err = 3'd0; e.fvec = 2'd0; e.fbits = 3'd0;
    for (int k = 0; k < 4; k++) begin
      a  = tb_vec[k][1];
      b  = tb_vec[k][0];
      ga = (fm == F_AND_SA0) ? 1'b0 : (a & b);
      go = a | b;
      gn = (fm == F_NOT_BUF) ? a : ~a;
      m  = {ga ^ (a & b), go ^ (a | b), gn ^ ~a};
      if (m != 3'd0) begin
        if (e.err == 3'd0) begin
          e.fvec  = 2'(k);
          e.fbits = m;
        end
        if (e.err != 3'd7) e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    checks++;
    if ({oA, oB, oBusy, oDone, oPass, oErrCnt, oFailVec, oFailBits} !== 13'd0) begin
      failures++;
      $display("FAIL %s: outputs=%b required all zero", tag,
               {oA, oB, oBusy, oDone, oPass, oErrCnt, oFailVec, oFailBits});
    end
  endtask

  // One full run; restart_n re-pulses iStart after that edge, reset_n_at aborts
  task automatic do_run(input int fm, input int restart_n, input int reset_n_at, input string tag);
    exp_t e;
    int n;
    fault_mode = fm;
    exp_q.push_back(model_run(fm));
    @(negedge iClk);
    iStart = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iStart = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge iClk);
      n++;
      @(negedge iClk);
      iStart = (n == restart_n) ? 1'b1 : 1'b0;
      if (n == reset_n_at) begin
        iRst_n = 1'b0;
        #1;
        check_all_zero({tag, "_midrun_reset"});
        void'(exp_q.pop_front());
        @(negedge iClk);
        iRst_n = 1'b1;
        return;
      end
      if (oDone) break;
      checks++;
      if (oPass !== 1'b0 || oBusy !== 1'b1) begin
        failures++;
        $display("FAIL %s_running n=%0d: pass=%b busy=%b required pass=0 busy=1", tag, n, oPass, oBusy);
      end
      if ((n - 1) % PERIOD == 0) begin
        checks++;
        if ({oA, oB} !== tb_vec[(n - 1) / PERIOD]) begin
          failures++;
          $display("FAIL %s_vector n=%0d: AB=%b required %b", tag, n, {oA, oB}, tb_vec[(n - 1) / PERIOD]);
        end
      end
    end
    iStart = 1'b0;
    checks++;
    if (n != RUN_EDGES) begin
      failures++;
      $display("FAIL %s_latency: done after %0d edges required %0d", tag, n, RUN_EDGES);
    end
    e = exp_q.pop_front();
    checks++;
    if ({oErrCnt, oFailVec, oFailBits, oPass, oBusy, oA, oB} !== {e.err, e.fvec, e.fbits, e.pass, 3'b000}) begin
      failures++;
      $display("FAIL %s_result: err=%0d fvec=%0d fbits=%b pass=%b busy=%b ab=%b%b required err=%0d fvec=%0d fbits=%b pass=%b busy=0 ab=00",
               tag, oErrCnt, oFailVec, oFailBits, oPass, oBusy, oA, oB, e.err, e.fvec, e.fbits, e.pass);
    end
    repeat (2) @(negedge iClk);
    checks++;
    if ({oDone, oPass, oErrCnt, oFailVec, oFailBits, oBusy, oA, oB} !== {1'b1, e.pass, e.err, e.fvec, e.fbits, 3'b000}) begin
      failures++;
      $display("FAIL %s_held: done=%b pass=%b err=%0d fvec=%0d fbits=%b busy=%b ab=%b%b required held results",
               tag, oDone, oPass, oErrCnt, oFailVec, oFailBits, oBusy, oA, oB);
    end
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iStart = 1'b0;
    repeat (2) @(negedge iClk);
    check_all_zero("reset_state");
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_correct();
    do_run(F_NONE, -1, -1, "correct");
  endtask

  task automatic test_and_stuck();
    do_run(F_AND_SA0, -1, -1, "and_sa0");
  endtask

  task automatic test_not_buf();
    do_run(F_NOT_BUF, -1, -1, "not_buf");
  endtask

  task automatic test_restart_ignored();
    do_run(F_AND_SA0, PERIOD + 4, -1, "restart_ignored");
  endtask

  task automatic test_reset_midrun();
    do_run(F_NONE, -1, 2 * PERIOD + 3, "abort");
    check_all_zero("after_abort");
    do_run(F_NONE, -1, -1, "after_abort_run");
  endtask

  task automatic test_back_to_back();
    do_run(F_NOT_BUF, -1, -1, "b2b_faulty");
    do_run(F_NONE, -1, -1, "b2b_clean");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    fault_mode = F_NONE;
    tb_vec[0] = 2'b00;
    tb_vec[1] = 2'b10;
    tb_vec[2] = 2'b01;
    tb_vec[3] = 2'b11;
    test_reset();
    test_correct();
    test_and_stuck();
    test_not_buf();
    test_restart_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
